request_encoder_4_to_2: RTL and testbench
=========================================

# request_encoder_4_to_2

Sequential 4-to-2 priority encoder for active-low request lines; it is the encoding counterpart of the 2-to-4 active-low decoder in the same logic library. It synchronises four asynchronous active-low request inputs and captures each falling edge as a pending request. It presents one 2-bit code at a time on a valid/ready handshake. Sits between external request/strobe lines (keys, interrupt pins, decoder outputs looped back) and a clocked consumer.

## Interface
- SYNC_STAGES, 2, synchroniser depth per request line (legal: ≥2)
- clk  input  1  rising-edge clock; one clock domain
- rst_n  input  1  asynchronous, active-low reset
- enable  input  1  active-low capture/issue enable
- in  input  4  active-low request lines, asynchronous to clk
- out  output  2  encoded index of presented request
- valid  output  1  out holds a request
- ready  input  1  consumer accepts out when valid & ready
- clear_ovr  input  1  one-cycle pulse, clears overrun flags
- overrun  output  4  sticky: request on line i lost (already pending)
- pending_cnt  output  3  number of captured, not yet presented requests (0–4)

## Operation
- Per line: SYNC_STAGES flip-flop synchroniser, then falling-edge detect (previous sync = 1, current sync = 0).
- Edge on line i while enable = 0: sets pending[i]. While enable = 1: edges are discarded; existing pending bits are kept.
- Edge on line i while pending[i] is already 1: sets overrun[i] and leaves pending[i] = 1.
- Edge on line i in the same cycle that pending[i] is consumed: pending[i] ends at 1. Set wins, and no overrun is flagged.
- clear_ovr and overrun set in the same cycle: set wins.
- Fixed priority: highest pending index wins (3 > 2 > 1 > 0).
- FSM, two states:
  - IDLE: valid = 0. If pending ≠ 0 and enable = 0, load out with the winner, clear its pending bit and set valid, then go to PRESENT.
  - PRESENT: valid = 1, and out is stable until handshake. On valid & ready: if pending ≠ 0 and enable = 0, load the next winner in the same cycle (back-to-back, valid stays 1). Otherwise go to IDLE with valid = 0.
  - An enable rise in PRESENT does not withdraw the current item; it only blocks the next load.
- pending_cnt is the registered popcount of pending.

## Timing
- Reset values: out = 2'b00, valid = 0, overrun = 4'b0000, pending_cnt = 0, state = IDLE, pending = 0.
- All synchroniser and edge-history flops reset to 1 (idle-high).
- A line held low through reset release is captured once as a new request.
- Latency: in low first sampled at edge t, then pending set at edge t+SYNC_STAGES, valid = 1 at edge t+SYNC_STAGES+1 (t+3 with defaults), when idle and enable = 0.
- Throughput: one code per cycle while ready = 1 and requests are pending.
- Input pulses shorter than one clock period are not guaranteed to be captured.
- Reset mid-operation: everything returns to reset values immediately (asynchronously); pending requests are dropped.

## Structure
- Package request_encoder_pkg:
  - state enum (IDLE, PRESENT)
  - CODE_W = 2, N_LINES = 4
  - priority-select function (pending → index)
- Sub-module sync_falling_edge (one line: SYNC_STAGES synchroniser plus edge-history flop, outputs a one-cycle edge pulse). Instantiated 4 times.
- Top level holds pending/overrun registers, FSM, popcount.

## Test plan
- Reset, enable = 0, ready = 1, in[2] falls at edge t → valid = 1 with out = 2'b10 at edge t+3, valid = 0 the next cycle, pending_cnt back to 0.
- in[0] and in[3] fall in the same cycle, ready = 0 → out = 2'b11 is held while ready = 0 and pending_cnt = 1. After ready = 1: out = 2'b11 accepted, then out = 2'b00 the next cycle, then valid = 0.
- in[1] toggles twice while pending[1] = 1 and ready = 0 → overrun = 4'b0010, pending_cnt = 1. A clear_ovr pulse then gives overrun = 0.
- enable = 1, in[2] falls → no capture, valid stays 0, pending_cnt = 0. enable = 1 while presenting 2'b01 → item completes on ready; queued 2'b00 is not issued until enable = 0.
- in[3] held low across reset release → exactly one out = 2'b11 transfer.
- rst_n asserted while valid = 1 with pending_cnt = 2 → all outputs go to reset values the same cycle; no further transfers after release with in all high.

Source files
------------

// File: rtl/request_encoder_pkg.sv
// Shared types, widths and helpers for the active-low request encoder.
package request_encoder_pkg;

  localparam int CODE_W  = 2;
  localparam int N_LINES = 4;
  localparam int CNT_W   = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

  // Highest set index wins; returns 0 for an all-zero vector.
  function automatic logic [CODE_W-1:0] prio_sel(input logic [N_LINES-1:0] req);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_LINES; i++) begin
      if (req[i]) idx = CODE_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [CNT_W-1:0] popcnt(input logic [N_LINES-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_LINES; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/request_encoder_4_to_2_if.sv
// Request lines, enable/clear controls and the code valid/ready handshake.
interface request_encoder_4_to_2_if;

  logic [request_encoder_pkg::N_LINES-1:0] in;
  logic                                    enable;
  logic [request_encoder_pkg::CODE_W-1:0]  out;
  logic                                    valid;
  logic                                    ready;
  logic                                    clear_ovr;
  logic [request_encoder_pkg::N_LINES-1:0] overrun;
  logic [request_encoder_pkg::CNT_W-1:0]   pending_cnt;

  modport master (
    output in, enable, ready, clear_ovr,
    input  out, valid, overrun, pending_cnt
  );

  modport slave (
    input  in, enable, ready, clear_ovr,
    output out, valid, overrun, pending_cnt
  );

endinterface

// File: rtl/request_encoder_4_to_2_sync_falling_edge.sv
// Purpose: synchronise one async active-low line and pulse on its falling edge.
// Latency: SYNC_STAGES cycles from first low sample to the edge pulse.
// Backpressure: none; the pulse is one cycle and must be consumed when seen.
module sync_falling_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Idle-high reset so a line held low through reset is seen as a fresh edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign fall_o = hist_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/request_encoder_4_to_2.sv
// Purpose: capture falling edges on four active-low lines, issue 2-bit codes by priority.
// Latency: valid SYNC_STAGES+1 cycles after first low sample; one code per cycle back-to-back.
// Backpressure: code held until ready; repeat edges on a pending line set overrun.
module request_encoder_4_to_2
  import request_encoder_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  request_encoder_4_to_2_if.slave  bus
);

  logic [N_LINES-1:0] fall;

  for (genvar g = 0; g < N_LINES; g++) begin : g_line
    sync_falling_edge #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .line_i (bus.in[g]),
      .fall_o (fall[g])
    );
  end

  state_e             state_q, state_d;
  logic [N_LINES-1:0] pending_q, pending_d;
  logic [N_LINES-1:0] overrun_q, overrun_d;
  logic [CODE_W-1:0]  out_q, out_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               load;
  logic [CODE_W-1:0]  winner;
  logic [N_LINES-1:0] consume;
  logic [N_LINES-1:0] cap;

  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    load      = 1'b0;
    winner    = prio_sel(pending_q);
    consume   = '0;
    cap       = '0;
    pending_d = pending_q;
    overrun_d = overrun_q;
    cnt_d     = cnt_q;

    case (state_q)
      IDLE: begin
        if ((|pending_q) && !bus.enable) begin
          load    = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (bus.ready) begin
          if ((|pending_q) && !bus.enable) load = 1'b1;
          else                             state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      out_d           = winner;
      consume[winner] = 1'b1;
    end

    // A fresh edge on a line being consumed this cycle re-arms it without overrun.
    if (!bus.enable) cap = fall;
    pending_d = (pending_q & ~consume) | cap;
    overrun_d = (bus.clear_ovr ? '0 : overrun_q) | (cap & pending_q & ~consume);
    cnt_d     = popcnt(pending_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      overrun_q <= '0;
      out_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      out_q     <= out_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.out         = out_q;
  assign bus.valid       = (state_q == PRESENT);
  assign bus.overrun     = overrun_q;
  assign bus.pending_cnt = cnt_q;

endmodule

// File: tb/tb_request_encoder_4_to_2.sv
// Randomised and directed bench with a cycle-level reference model and code scoreboard.
module tb_request_encoder_4_to_2;

  localparam int SYNC = 2;
  localparam int MAXC = 8192;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  request_encoder_4_to_2_if bus ();

  request_encoder_4_to_2 #(
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int xfers  = 0;

  function automatic void check(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: input sample log per active cycle, pending set, FIFO of expected codes.
  logic [3:0] samp [0:MAXC-1];
  int         cyc  = 0;
  int         base = 0;
  bit   [3:0] m_pend = '0;
  bit   [3:0] m_ovr  = '0;
  bit         m_busy = 1'b0;
  int         exp_q [$];

  function automatic bit sampv(int k, int i);
    if (k < base) return 1'b1;
    return samp[k][i];
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_pend = '0;
        m_ovr  = '0;
        m_busy = 1'b0;
        exp_q.delete();
        base   = cyc;
      end else begin
        bit [3:0] cap;
        bit [3:0] cons;
        bit [3:0] old;
        int       w;
        if (cyc < MAXC) samp[cyc] = bus.in;
        cap  = '0;
        cons = '0;
        old  = m_pend;
        for (int i = 0; i < 4; i++) begin
          if (!bus.enable && sampv(cyc - SYNC - 1, i) && !sampv(cyc - SYNC, i)) cap[i] = 1'b1;
        end
        if (old != 0 && !bus.enable && (!m_busy || bus.ready)) begin
          w = 0;
          for (int i = 3; i >= 0; i--) begin
            if (old[i]) begin
              w = i;
              break;
            end
          end
          cons[w] = 1'b1;
          exp_q.push_back(w);
          m_busy = 1'b1;
        end else if (m_busy && bus.ready) begin
          m_busy = 1'b0;
        end
        if (bus.clear_ovr) m_ovr = '0;
        m_ovr  = m_ovr | (cap & old & ~cons);
        m_pend = (old & ~cons) | cap;
        cyc++;
      end
    end
  end

  // Monitor: compares flags every cycle and pops the scoreboard on each handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("valid", int'(bus.valid), int'(m_busy));
        check("overrun", int'(bus.overrun), int'(m_ovr));
        check("pending_cnt", int'(bus.pending_cnt), $countones(m_pend));
        if (bus.valid && bus.ready) begin
          xfers++;
          check("xfer_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) check("code", int'(bus.out), exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int x0;

  initial begin
    bus.in        = 4'hF;
    bus.enable    = 1'b0;
    bus.ready     = 1'b1;
    bus.clear_ovr = 1'b0;
    tick(3);
    check("rst_out", int'(bus.out), 0);
    check("rst_valid", int'(bus.valid), 0);
    check("rst_overrun", int'(bus.overrun), 0);
    check("rst_cnt", int'(bus.pending_cnt), 0);
    rst_n = 1'b1;
    tick(3);

    // Single request: code 2 appears three edges after first low sample.
    bus.in[2] = 1'b0;
    tick(4);
    check("s1_valid", int'(bus.valid), 1);
    check("s1_out", int'(bus.out), 2);
    tick(1);
    check("s1_valid_drop", int'(bus.valid), 0);
    check("s1_cnt", int'(bus.pending_cnt), 0);
    bus.in = 4'hF;
    tick(4);

    // Simultaneous 0 and 3 with ready low.
    bus.ready = 1'b0;
    bus.in    = 4'b0110;
    tick(6);
    check("s2_valid", int'(bus.valid), 1);
    check("s2_out_hold", int'(bus.out), 3);
    check("s2_cnt", int'(bus.pending_cnt), 1);
    bus.ready = 1'b1;
    tick(1);
    check("s2_b2b_valid", int'(bus.valid), 1);
    check("s2_b2b_out", int'(bus.out), 0);
    tick(1);
    check("s2_idle", int'(bus.valid), 0);
    bus.in = 4'hF;
    tick(4);

    // Overrun on line 1 while it is still pending.
    bus.ready = 1'b0;
    bus.in[3] = 1'b0;
    tick(5);
    check("s3_out", int'(bus.out), 3);
    bus.in[1] = 1'b0;
    tick(3);
    check("s3_cnt_first", int'(bus.pending_cnt), 1);
    bus.in[1] = 1'b1; tick(2);
    bus.in[1] = 1'b0; tick(2);
    bus.in[1] = 1'b1; tick(2);
    bus.in[1] = 1'b0; tick(4);
    check("s3_overrun", int'(bus.overrun), 2);
    check("s3_cnt", int'(bus.pending_cnt), 1);
    bus.clear_ovr = 1'b1;
    tick(1);
    bus.clear_ovr = 1'b0;
    check("s3_cleared", int'(bus.overrun), 0);
    bus.ready = 1'b1;
    tick(3);
    bus.in = 4'hF;
    tick(4);

    // Enable high blocks capture, then blocks the next load only.
    bus.enable = 1'b1;
    bus.in[2]  = 1'b0;
    tick(6);
    check("s4_no_valid", int'(bus.valid), 0);
    check("s4_no_cnt", int'(bus.pending_cnt), 0);
    bus.in = 4'hF;
    tick(4);
    bus.enable = 1'b0;
    bus.ready  = 1'b0;
    bus.in     = 4'b1100;
    tick(5);
    check("s4_present", int'(bus.out), 1);
    check("s4_cnt_q", int'(bus.pending_cnt), 1);
    bus.enable = 1'b1;
    bus.ready  = 1'b1;
    tick(1);
    check("s4_done", int'(bus.valid), 0);
    tick(3);
    check("s4_blocked", int'(bus.valid), 0);
    check("s4_blocked_cnt", int'(bus.pending_cnt), 1);
    bus.enable = 1'b0;
    tick(1);
    check("s4_resume_valid", int'(bus.valid), 1);
    check("s4_resume_out", int'(bus.out), 0);
    tick(1);
    bus.in = 4'hF;
    tick(4);

    // Line held low through reset release is one request.
    rst_n     = 1'b0;
    bus.in[3] = 1'b0;
    tick(2);
    rst_n = 1'b1;
    x0    = xfers;
    tick(8);
    check("s5_one_xfer", xfers - x0, 1);
    bus.in = 4'hF;
    tick(4);

    // Asynchronous reset while presenting with two queued.
    bus.ready = 1'b0;
    bus.in    = 4'b1000;
    tick(5);
    check("s6_out", int'(bus.out), 2);
    check("s6_cnt", int'(bus.pending_cnt), 2);
    rst_n = 1'b0;
    #1;
    check("s6_rst_valid", int'(bus.valid), 0);
    check("s6_rst_out", int'(bus.out), 0);
    check("s6_rst_ovr", int'(bus.overrun), 0);
    check("s6_rst_cnt", int'(bus.pending_cnt), 0);
    bus.in    = 4'hF;
    bus.ready = 1'b1;
    tick(2);
    rst_n = 1'b1;
    x0    = xfers;
    tick(10);
    check("s6_no_xfer", xfers - x0, 0);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 5) == 0) bus.in[i] = ~bus.in[i];
      end
      bus.ready     = ($urandom_range(0, 3) != 0);
      bus.enable    = ($urandom_range(0, 9) == 0);
      bus.clear_ovr = ($urandom_range(0, 29) == 0);
      tick(1);
    end
    bus.in        = 4'hF;
    bus.enable    = 1'b0;
    bus.ready     = 1'b1;
    bus.clear_ovr = 1'b0;
    tick(20);
    check("drain_queue", exp_q.size(), 0);
    check("drain_valid", int'(bus.valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
